hansen_pcie_host_initiator: RTL and testbench

Host-side end of the Hansen PCIe mock link. It accepts word read/write requests from a host model or driver over a valid/ready port and buffers them in a small FIFO. It serialises them onto the SoC's link inputs (valid, 64-bit packet, write flag) and collects read completions from the SoC's link outputs. It sits outside the SoC and drives the same link the SoC's PCIe endpoint receives. Reads carry a timeout, so a silent endpoint never hangs the host.

---
 rtl/hansen_pcie_pkg.sv | 33 +++
 rtl/hansen_pcie_host_initiator_fifo.sv | 54 +++++
 rtl/hansen_pcie_host_initiator.sv | 162 ++++++++++++++++
 tb/tb_hansen_pcie_host_initiator.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hansen_pcie_pkg.sv
// hansen_pcie_pkg: shared constants and types for the Hansen PCIe host initiator.
// Packet field offsets, FSM encoding, the request record and a packet builder.
package hansen_pcie_pkg;

  localparam int ADDR_MSB = 63;
  localparam int ADDR_LSB = 32;
  localparam int DATA_MSB = 31;
  localparam int DATA_LSB = 0;

  localparam int REQ_W = 65;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_RESP  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // Word-aligned address on top, write data (or 0 for reads) below.
  function automatic logic [63:0] make_pkt(input req_t r);
    logic [63:0] p;
    p = '0;
    p[ADDR_MSB:ADDR_LSB] = {r.addr[31:2], 2'b00};
    p[DATA_MSB:DATA_LSB] = r.write ? r.wdata : 32'h0;
    return p;
  endfunction

endpackage

// File: rtl/hansen_pcie_host_initiator_fifo.sv
// hansen_req_fifo: synchronous request FIFO, async active-low reset.
// Ports: i_push/i_din in, i_pop/o_dout out (head), o_full, o_empty, o_count.
module hansen_req_fifo
  import hansen_pcie_pkg::*;
#(
  parameter int WIDTH = REQ_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_cnt;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_cnt == FULL_CNT);
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_dout  = r_mem[r_rd];
  assign o_count = r_cnt;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end

  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

endmodule

// File: rtl/hansen_pcie_host_initiator.sv
// hansen_pcie_host_initiator: host end of the Hansen PCIe mock link.
// Queues host word requests, strobes them onto the link, returns reads.
// Ports: clk, reset_n; req_* host request in (valid/ready);
//   rsp_* read response out (held until rsp_ready); link_* packet to SoC;
//   cpl_* completion from SoC; stray_cpl_count saturating stray counter.
module hansen_pcie_host_initiator
  import hansen_pcie_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int GAP_CYCLES     = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_error,
  output logic        link_valid,
  output logic [63:0] link_data,
  output logic        link_is_write,
  input  logic        cpl_valid,
  input  logic [31:0] cpl_data,
  output logic [7:0]  stray_cpl_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] TMO      = CW'(TIMEOUT_CYCLES);
  localparam logic [3:0]    GAP_LAST = 4'(GAP_CYCLES - 1);
  localparam logic [2:0]    ST_POST  =
    (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

  logic [2:0]    r_state;
  req_t          r_issue;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_gap;
  logic          r_req_ready;
  logic          r_rsp_valid;
  logic [31:0]   r_rsp_data;
  logic          r_rsp_error;
  logic          r_link_valid;
  logic [63:0]   r_link_data;
  logic          r_link_is_write;
  logic [7:0]    r_stray;

  req_t          w_req_in;
  req_t          w_head;
  logic          w_full;
  logic          w_empty;
  logic [AW:0]   w_count;
  logic [AW:0]   w_cnt_next;
  logic          w_push;
  logic          w_pop;

  assign w_req_in = '{write: req_write, addr: req_addr, wdata: req_wdata};
  assign w_push   = req_valid && r_req_ready && !w_full;
  assign w_pop    = (r_state == ST_IDLE) && !w_empty;
  assign w_cnt_next = w_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

  hansen_req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_din   (w_req_in),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Ready is a register tracking the next count, so it stays off
  // through reset and has no input-to-output path.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_req_ready <= 1'b0;
    else          r_req_ready <= (w_cnt_next != FULL_CNT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= ST_IDLE;
      r_issue         <= '0;
      r_cnt           <= '0;
      r_gap           <= '0;
      r_rsp_valid     <= 1'b0;
      r_rsp_data      <= '0;
      r_rsp_error     <= 1'b0;
      r_link_valid    <= 1'b0;
      r_link_data     <= '0;
      r_link_is_write <= 1'b0;
      r_stray         <= '0;
    end else begin
      r_link_valid <= 1'b0;
      if (cpl_valid && (r_state != ST_WAIT) && (r_stray != 8'hFF))
        r_stray <= r_stray + 8'd1;
      unique case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_issue <= w_head;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_link_valid    <= 1'b1;
          r_link_data     <= make_pkt(r_issue);
          r_link_is_write <= r_issue.write;
          r_gap           <= '0;
          r_cnt           <= '0;
          r_state <= r_issue.write ? ST_POST : ST_WAIT;
        end
        ST_WAIT: begin
          // A completion in the timeout cycle still wins.
          if (cpl_valid) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= cpl_data;
            r_rsp_error <= 1'b0;
            r_state     <= ST_RESP;
          end else if (r_cnt == TMO) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= '0;
            r_rsp_error <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_gap       <= '0;
            r_state     <= ST_POST;
          end
        end
        ST_GAP: begin
          if (r_gap == GAP_LAST) r_state <= ST_IDLE;
          else                   r_gap   <= r_gap + 4'd1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready       = r_req_ready;
  assign rsp_valid       = r_rsp_valid;
  assign rsp_data        = r_rsp_data;
  assign rsp_error       = r_rsp_error;
  assign link_valid      = r_link_valid;
  assign link_data       = r_link_data;
  assign link_is_write   = r_link_is_write;
  assign stray_cpl_count = r_stray;

endmodule

// File: tb/tb_hansen_pcie_host_initiator.sv
// tb_hansen_pcie_host_initiator: directed + random bench for the host
// initiator, checked against a transaction-timing reference model.
module tb_hansen_pcie_host_initiator;

  localparam int D = 4;
  localparam int G = 1;
  localparam int T = 8;
  localparam int BIG = 1 << 30;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_error;
  logic        link_valid;
  logic [63:0] link_data;
  logic        link_is_write;
  logic        cpl_valid;
  logic [31:0] cpl_data;
  logic [7:0]  stray_cpl_count;

  hansen_pcie_host_initiator #(
    .FIFO_DEPTH     (D),
    .GAP_CYCLES     (G),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_data        (rsp_data),
    .rsp_error       (rsp_error),
    .link_valid      (link_valid),
    .link_data       (link_data),
    .link_is_write   (link_is_write),
    .cpl_valid       (cpl_valid),
    .cpl_data        (cpl_data),
    .stray_cpl_count (stray_cpl_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: requests in a queue, engine availability as the
  // edge number at which it may next take a request.
  typedef struct {
    bit        w;
    bit [31:0] a;
    bit [31:0] d;
  } mreq_t;

  mreq_t     q[$];
  mreq_t     cur;
  int        cyc = 0;
  int        idle_at;
  bit        issuing;
  int        issue_edge;
  bit        waiting;
  int        wait_start;
  bit        exp_lv;
  bit [63:0] exp_ld;
  bit        exp_lw;
  bit        exp_rv;
  bit [31:0] exp_rd;
  bit        exp_re;
  bit        exp_ready;
  int        exp_stray;

  function automatic bit [63:0] pkt(input mreq_t r);
    bit [31:0] a;
    a = r.a & 32'hFFFF_FFFC;
    return {a, (r.w ? r.d : 32'h0)};
  endfunction

  task automatic model_reset();
    q.delete();
    idle_at   = 0;
    issuing   = 0;
    waiting   = 0;
    exp_lv    = 0;
    exp_rv    = 0;
    exp_rd    = 0;
    exp_re    = 0;
    exp_ready = 0;
    exp_stray = 0;
  endtask

  task automatic model_edge();
    bit was_wait;
    cyc++;
    exp_lv   = 0;
    was_wait = waiting;
    if (cpl_valid && !was_wait && exp_stray != 255) exp_stray++;
    if (exp_rv && rsp_ready) begin
      exp_rv  = 0;
      idle_at = cyc + G + 1;
    end
    if (was_wait) begin
      if (cpl_valid) begin
        exp_rv = 1; exp_rd = cpl_data; exp_re = 0; waiting = 0;
      end else if (cyc == wait_start + T + 1) begin
        exp_rv = 1; exp_rd = 0; exp_re = 1; waiting = 0;
      end
    end
    if (issuing && cyc == issue_edge) begin
      issuing = 0;
      exp_lv  = 1;
      exp_ld  = pkt(cur);
      exp_lw  = cur.w;
      if (cur.w) idle_at = cyc + G + 1;
      else begin
        waiting    = 1;
        wait_start = cyc;
      end
    end
    if (cyc >= idle_at && q.size() > 0) begin
      cur        = q.pop_front();
      issuing    = 1;
      issue_edge = cyc + 1;
      idle_at    = BIG;
    end
    if (req_valid && exp_ready)
      q.push_back('{w: req_write, a: req_addr, d: req_wdata});
    exp_ready = (q.size() < D);
  endtask

  task automatic check_outputs();
    chk("link_valid", 64'(link_valid), 64'(exp_lv));
    if (exp_lv) begin
      chk("link_data", link_data, exp_ld);
      chk("link_is_write", 64'(link_is_write), 64'(exp_lw));
    end
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    if (exp_rv) begin
      chk("rsp_data", 64'(rsp_data), 64'(exp_rd));
      chk("rsp_error", 64'(rsp_error), 64'(exp_re));
    end
    chk("stray_cpl_count", 64'(stray_cpl_count), 64'(exp_stray));
  endtask

  task automatic drive(input bit v, input bit w, input bit [31:0] a,
                       input bit [31:0] d, input bit cv,
                       input bit [31:0] cd, input bit rr);
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    cpl_valid = cv;
    cpl_data  = cd;
    rsp_ready = rr;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n, input bit rr);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, rr);
  endtask

  task automatic apply_reset();
    req_valid = 0;
    cpl_valid = 0;
    rsp_ready = 0;
    reset_n   = 1'b0;
    #1;
    model_reset();
    chk("rst req_ready", 64'(req_ready), 64'd0);
    chk("rst rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst rsp_data", 64'(rsp_data), 64'd0);
    chk("rst rsp_error", 64'(rsp_error), 64'd0);
    chk("rst link_valid", 64'(link_valid), 64'd0);
    chk("rst link_data", link_data, 64'd0);
    chk("rst link_is_write", 64'(link_is_write), 64'd0);
    chk("rst stray", 64'(stray_cpl_count), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic push_writes(input int n, input bit [31:0] base);
    int k;
    k = 0;
    for (int c = 0; c < 60 && k < n; c++) begin
      bit acc;
      acc = exp_ready;
      drive(1, 1, base + 32'(k * 4), 32'hA000_0000 + 32'(k), 0, 0, 1);
      if (acc) k++;
    end
    chk("push count", 64'(k), 64'(n));
  endtask

  initial begin
    reset_n   = 1'b1;
    req_valid = 0;
    req_write = 0;
    req_addr  = 0;
    req_wdata = 0;
    cpl_valid = 0;
    cpl_data  = 0;
    rsp_ready = 0;
    #3;
    apply_reset();
    idle(3, 0);

    // single posted write
    drive(1, 1, 32'h0000_0010, 32'hCAFE_F00D, 0, 0, 0);
    idle(6, 0);

    // read, completion 3 cycles after issue, response held 5 cycles
    drive(1, 0, 32'h0000_0013, 32'hDEAD_BEEF, 0, 0, 0);
    idle(4, 0);
    drive(0, 0, 0, 0, 1, 32'h1234_5678, 0);
    idle(5, 0);
    idle(1, 1);
    idle(6, 0);

    // read timeout
    drive(1, 0, 32'h0000_0100, 0, 0, 0, 1);
    idle(16, 1);

    // completion exactly in the timeout cycle
    drive(1, 0, 32'h0000_0200, 0, 0, 0, 1);
    idle(10, 1);
    drive(0, 0, 0, 0, 1, 32'h5555_AAAA, 1);
    idle(6, 1);

    // FIFO fill and back-to-back write spacing
    push_writes(6, 32'h0000_1000);
    idle(25, 1);

    // FIFO held full behind a timing-out read
    drive(1, 0, 32'h0000_2000, 0, 0, 0, 1);
    push_writes(6, 32'h0000_3000);
    idle(40, 1);

    // stray completions in idle, then saturation
    drive(0, 0, 0, 0, 1, 32'h1, 1);
    idle(3, 1);
    for (int i = 0; i < 260; i++) drive(0, 0, 0, 0, 1, 32'h2, 1);
    idle(3, 1);

    // reset while waiting for a completion with two writes queued
    drive(1, 0, 32'h0000_4000, 0, 0, 0, 1);
    idle(2, 1);
    drive(1, 1, 32'h0000_4004, 32'h1, 0, 0, 1);
    drive(1, 1, 32'h0000_4008, 32'h2, 0, 0, 1);
    apply_reset();
    idle(20, 1);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 9) < 4,
            $urandom_range(0, 1) == 1,
            $urandom, $urandom,
            $urandom_range(0, 9) == 0,
            $urandom,
            $urandom_range(0, 9) < 6);
    end
    idle(30, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
